ptw_port_arbiter: RTL and testbench

Shares the single AXI-master read port used for page-table walks between the ITLB and the DTLB. Each TLB issues one PTE-read request per walk level as a one-cycle pulse. The arbiter captures that pulse, grants the port round-robin, and returns the PTE to the requester as a one-cycle data pulse. A response timeout produces an access fault instead of hanging a walk, and a drain state discards the late response that follows a timeout.

---
 rtl/ptw_arb_pkg.sv | 18 +
 rtl/ptw_req_slot.sv | 56 +++++
 rtl/ptw_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ptw_port_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_arb_pkg.sv
// Shared types for the page-table-walk port arbiter: FSM states and requester IDs.
package ptw_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDrain = 2'd3
  } arb_state_e;

  typedef enum logic {
    ReqI = 1'b0,
    ReqD = 1'b1
  } req_id_e;

  localparam int unsigned NumReq = 2;

endpackage

// File: rtl/ptw_req_slot.sv
// One-deep request slot: captures a TLB request pulse and tracks it until its response returns.
module ptw_req_slot #(
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  grant,
  input  logic                  free,
  output logic                  pending,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  proto_err
);

  logic                  pending_q, pending_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  busy;

  always_comb begin
    busy       = pending_q | inflight_q;
    pending_d  = pending_q;
    inflight_d = inflight_q;
    addr_d     = addr_q;
    // A pulse on an occupied slot is dropped and flagged.
    proto_err  = req_valid & busy;
    if (req_valid && !busy) begin
      pending_d = 1'b1;
      addr_d    = req_addr;
    end
    if (grant) begin
      pending_d  = 1'b0;
      inflight_d = 1'b1;
    end
    if (free) begin
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending_q  <= 1'b0;
      inflight_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      addr_q     <= addr_d;
    end
  end

  assign pending = pending_q;
  assign addr    = addr_q;

endmodule

// File: rtl/ptw_port_arbiter.sv
// Round-robin sharing of one AXI read port between ITLB and DTLB page-table walks,
// with a response timeout that faults the walk and drains the late response.
module ptw_port_arbiter
  import ptw_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 11
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  I_REQ_VALID,
  input  logic [ADDR_WIDTH-1:0] I_REQ_ADDR,
  output logic                  I_RESP_VALID,
  output logic [DATA_WIDTH-1:0] I_RESP_DATA,
  output logic                  I_ACCESS_FAULT,
  input  logic                  D_REQ_VALID,
  input  logic [ADDR_WIDTH-1:0] D_REQ_ADDR,
  output logic                  D_RESP_VALID,
  output logic [DATA_WIDTH-1:0] D_RESP_DATA,
  output logic                  D_ACCESS_FAULT,
  output logic                  M_REQ_VALID,
  output logic [ADDR_WIDTH-1:0] M_REQ_ADDR,
  input  logic                  M_REQ_READY,
  input  logic                  M_RESP_VALID,
  input  logic [DATA_WIDTH-1:0] M_RESP_DATA,
  input  logic                  M_RESP_ERR,
  output logic                  BUSY,
  output logic                  PROTO_ERR
);

  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

  logic [NumReq-1:0]                 slot_pending, slot_grant, slot_free, slot_proto;
  logic [NumReq-1:0][ADDR_WIDTH-1:0] slot_addr;

  arb_state_e                        state_q, state_d;
  req_id_e                           owner_q, owner_d, last_q, last_d, win;
  logic [CNT_WIDTH-1:0]              cnt_q, cnt_d;
  logic                              m_valid_q, m_valid_d;
  logic [ADDR_WIDTH-1:0]             m_addr_q, m_addr_d;
  logic [NumReq-1:0]                 resp_valid_q, resp_valid_d;
  logic [NumReq-1:0]                 resp_fault_q, resp_fault_d;
  logic [NumReq-1:0][DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                              busy_q, busy_d;
  logic                              proto_q, proto_d;

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot_i (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (I_REQ_VALID),
    .req_addr  (I_REQ_ADDR),
    .grant     (slot_grant[ReqI]),
    .free      (slot_free[ReqI]),
    .pending   (slot_pending[ReqI]),
    .addr      (slot_addr[ReqI]),
    .proto_err (slot_proto[ReqI])
  );

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot_d (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (D_REQ_VALID),
    .req_addr  (D_REQ_ADDR),
    .grant     (slot_grant[ReqD]),
    .free      (slot_free[ReqD]),
    .pending   (slot_pending[ReqD]),
    .addr      (slot_addr[ReqD]),
    .proto_err (slot_proto[ReqD])
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    m_valid_d    = m_valid_q;
    m_addr_d     = m_addr_q;
    resp_valid_d = '0;
    resp_fault_d = '0;
    resp_data_d  = resp_data_q;
    slot_grant   = '0;
    slot_free    = '0;
    proto_d      = proto_q | (|slot_proto);

    // On a tie the requester that was not served last wins.
    win = ReqI;
    if (&slot_pending) begin
      win = (last_q == ReqI) ? ReqD : ReqI;
    end else if (slot_pending[ReqD]) begin
      win = ReqD;
    end

    unique case (state_q)
      StIdle: begin
        if (|slot_pending) begin
          slot_grant[win] = 1'b1;
          owner_d         = win;
          last_d          = win;
          m_valid_d       = 1'b1;
          m_addr_d        = slot_addr[win];
          state_d         = StIssue;
        end
        if (M_RESP_VALID) proto_d = 1'b1;
      end
      StIssue: begin
        if (M_REQ_READY) begin
          m_valid_d = 1'b0;
          cnt_d     = '0;
          state_d   = StWait;
        end
        if (M_RESP_VALID) proto_d = 1'b1;
      end
      StWait: begin
        if (M_RESP_VALID) begin
          resp_valid_d[owner_q] = 1'b1;
          resp_fault_d[owner_q] = M_RESP_ERR;
          resp_data_d[owner_q]  = M_RESP_DATA;
          slot_free[owner_q]    = 1'b1;
          state_d               = StIdle;
        end else if (cnt_q == CntLast) begin
          resp_valid_d[owner_q] = 1'b1;
          resp_fault_d[owner_q] = 1'b1;
          resp_data_d[owner_q]  = '0;
          slot_free[owner_q]    = 1'b1;
          state_d               = StDrain;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StDrain: begin
        // The response belonging to the timed-out request is discarded here.
        if (M_RESP_VALID) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      owner_q      <= ReqI;
      last_q       <= ReqD;
      cnt_q        <= '0;
      m_valid_q    <= 1'b0;
      m_addr_q     <= '0;
      resp_valid_q <= '0;
      resp_fault_q <= '0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
      proto_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      m_valid_q    <= m_valid_d;
      m_addr_q     <= m_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_data_q  <= resp_data_d;
      busy_q       <= busy_d;
      proto_q      <= proto_d;
    end
  end

  assign I_RESP_VALID   = resp_valid_q[ReqI];
  assign I_RESP_DATA    = resp_data_q[ReqI];
  assign I_ACCESS_FAULT = resp_fault_q[ReqI];
  assign D_RESP_VALID   = resp_valid_q[ReqD];
  assign D_RESP_DATA    = resp_data_q[ReqD];
  assign D_ACCESS_FAULT = resp_fault_q[ReqD];
  assign M_REQ_VALID    = m_valid_q;
  assign M_REQ_ADDR     = m_addr_q;
  assign BUSY           = busy_q;
  assign PROTO_ERR      = proto_q;

endmodule

// File: tb/tb_ptw_port_arbiter.sv
// Scoreboard bench for ptw_port_arbiter: address-driven memory/latency model, per-requester
// expected queues, and a negedge monitor that checks every response pulse.
module tb_ptw_port_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned TO = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req_valid, d_req_valid;
  logic [AW-1:0] i_req_addr, d_req_addr;
  logic          i_resp_valid, d_resp_valid, i_fault, d_fault;
  logic [DW-1:0] i_resp_data, d_resp_data;
  logic          m_req_valid, m_req_ready, m_resp_valid, m_resp_err;
  logic [AW-1:0] m_req_addr;
  logic [DW-1:0] m_resp_data;
  logic          busy, proto_err;

  always #5 clk = ~clk;

  ptw_port_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (CW)
  ) dut (
    .CLK            (clk),
    .RST_N          (rst_n),
    .I_REQ_VALID    (i_req_valid),
    .I_REQ_ADDR     (i_req_addr),
    .I_RESP_VALID   (i_resp_valid),
    .I_RESP_DATA    (i_resp_data),
    .I_ACCESS_FAULT (i_fault),
    .D_REQ_VALID    (d_req_valid),
    .D_REQ_ADDR     (d_req_addr),
    .D_RESP_VALID   (d_resp_valid),
    .D_RESP_DATA    (d_resp_data),
    .D_ACCESS_FAULT (d_fault),
    .M_REQ_VALID    (m_req_valid),
    .M_REQ_ADDR     (m_req_addr),
    .M_REQ_READY    (m_req_ready),
    .M_RESP_VALID   (m_resp_valid),
    .M_RESP_DATA    (m_resp_data),
    .M_RESP_ERR     (m_resp_err),
    .BUSY           (busy),
    .PROTO_ERR      (proto_err)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          fault;
    bit            to;
  } exp_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  exp_t          i_exp[$], d_exp[$];
  rsp_t          rsp_q[$];
  logic [AW-1:0] grant_q[$];
  int            acc_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            last_resp_cyc = -100;
  int            last_acc_cyc = -100;
  bit            i_out = 1'b0;
  bit            d_out = 1'b0;
  bit            prev_wait = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  // Memory model: the address encodes data, bus error, response delay and READY stall.
  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return a ^ 64'h0000_0000_A000_10CF;
  endfunction

  function automatic int dly_of(input logic [AW-1:0] a);
    logic [3:0] f;
    f = a[11:8];
    return (f == 4'd0) ? 3 : int'(f);
  endfunction

  function automatic int rdy_of(input logic [AW-1:0] a);
    logic [3:0] f;
    f = a[19:16];
    return int'(f);
  endfunction

  // A response k cycles after acceptance is delivered if k <= TO, otherwise the walk faults.
  function automatic exp_t model(input logic [AW-1:0] a);
    exp_t e;
    if (dly_of(a) > int'(TO)) begin
      e.data = '0; e.fault = 1'b1; e.to = 1'b1;
    end else begin
      e.data = data_of(a); e.fault = a[3]; e.to = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = {$urandom, $urandom};
    a[19:16] = 4'($urandom_range(0, 3));
    a[11:8]  = ($urandom_range(0, 7) == 0) ? 4'd12 : 4'($urandom_range(1, 8));
    return a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_i_valid"}, 64'(i_resp_valid), 0);
    chk({tag, "_i_data"}, i_resp_data, 0);
    chk({tag, "_i_fault"}, 64'(i_fault), 0);
    chk({tag, "_d_valid"}, 64'(d_resp_valid), 0);
    chk({tag, "_d_data"}, d_resp_data, 0);
    chk({tag, "_d_fault"}, 64'(d_fault), 0);
    chk({tag, "_m_valid"}, 64'(m_req_valid), 0);
    chk({tag, "_m_addr"}, m_req_addr, 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_proto"}, 64'(proto_err), 0);
  endtask

  task automatic issue(input bit do_i, input logic [AW-1:0] ai, input bit do_d,
                       input logic [AW-1:0] ad);
    if (do_i) begin
      i_req_valid = 1'b1; i_req_addr = ai; i_exp.push_back(model(ai)); i_out = 1'b1;
    end
    if (do_d) begin
      d_req_valid = 1'b1; d_req_addr = ad; d_exp.push_back(model(ad)); d_out = 1'b1;
    end
    tick();
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((i_out || d_out || busy || rsp_q.size() > 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic got_resp(input bit is_d, input logic [DW-1:0] data, input logic fault);
    exp_t  e;
    bit    have;
    string who;
    who  = is_d ? "d" : "i";
    have = 1'b0;
    if (is_d && d_exp.size() > 0) begin e = d_exp.pop_front(); have = 1'b1; end
    if (!is_d && i_exp.size() > 0) begin e = i_exp.pop_front(); have = 1'b1; end
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL %s_resp_expected: got an unrequested pulse, required none", who);
    end else begin
      chk({who, "_resp_data"}, data, e.data);
      chk({who, "_resp_fault"}, 64'(fault), 64'(e.fault));
      if (e.to) chk({who, "_timeout_cycle"}, 64'(cyc), 64'(last_acc_cyc + int'(TO) + 1));
      else chk({who, "_resp_cycle"}, 64'(cyc), 64'(last_resp_cyc + 1));
    end
    if (is_d) d_out = 1'b0;
    else i_out = 1'b0;
  endtask

  // AXI slave model: stalls READY by rdy_of(addr), answers dly_of(addr) cycles after acceptance.
  initial begin
    int wait_left;
    bit seen;
    rsp_t r;
    seen = 1'b0; wait_left = 0;
    m_req_ready = 1'b1; m_resp_valid = 1'b0; m_resp_data = '0; m_resp_err = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      m_resp_valid = 1'b0;
      m_resp_err   = 1'b0;
      if (!rst_n) begin
        rsp_q.delete();
        seen = 1'b0;
        m_req_ready = 1'b1;
      end else begin
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
          m_resp_valid  = 1'b1;
          m_resp_data   = rsp_q[0].data;
          m_resp_err    = rsp_q[0].err;
          last_resp_cyc = cyc;
          rsp_q.delete(0);
        end
        if (m_req_valid) begin
          if (!seen) begin
            seen = 1'b1;
            wait_left = rdy_of(m_req_addr);
          end
          if (wait_left == 0) begin
            m_req_ready = 1'b1;
            seen = 1'b0;
            r.due = cyc + dly_of(m_req_addr);
            r.data = data_of(m_req_addr);
            r.err = m_req_addr[3];
            rsp_q.push_back(r);
          end else begin
            m_req_ready = 1'b0;
            wait_left--;
          end
        end else begin
          m_req_ready = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wait = 1'b0;
    end else begin
      if (i_resp_valid) got_resp(1'b0, i_resp_data, i_fault);
      else chk("i_fault_idle", 64'(i_fault), 0);
      if (d_resp_valid) got_resp(1'b1, d_resp_data, d_fault);
      else chk("d_fault_idle", 64'(d_fault), 0);
      if (prev_wait) begin
        chk("mreq_hold_valid", 64'(m_req_valid), 1);
        chk("mreq_hold_addr", m_req_addr, prev_addr);
      end
      if (m_req_valid && m_req_ready) begin
        grant_q.push_back(m_req_addr);
        acc_q.push_back(cyc);
        last_acc_cyc = cyc;
      end
      prev_wait = m_req_valid && !m_req_ready;
      prev_addr = m_req_addr;
    end
  end

  initial begin
    logic [AW-1:0] a1, b1, a2, b2, at, it;
    int t0, n;
    i_req_valid = 1'b0; d_req_valid = 1'b0; i_req_addr = '0; d_req_addr = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset("por");
    rst_n = 1'b1;
    tick();

    // Simultaneous pulses from reset: ITLB wins the first tie.
    a1 = 64'h0000_0000_1111_0210;
    b1 = 64'h0000_0000_2222_0300;
    grant_q.delete();
    issue(1'b1, a1, 1'b1, b1);
    wait_done("round1");
    chk("round1_grants", 64'(grant_q.size()), 2);
    if (grant_q.size() >= 2) begin
      chk("round1_first", grant_q[0], a1);
      chk("round1_second", grant_q[1], b1);
    end

    // Single ITLB walk, READY high, response three cycles after acceptance.
    grant_q.delete();
    issue(1'b1, 64'h0000_0000_8000_1000, 1'b0, '0);
    chk("t1_mreq_early", 64'(m_req_valid), 0);
    tick();
    chk("t1_mreq_valid", 64'(m_req_valid), 1);
    chk("t1_mreq_addr", m_req_addr, 64'h0000_0000_8000_1000);
    wait_done("single");
    chk("t1_grants", 64'(grant_q.size()), 1);

    // Last grant is now ITLB, so the DTLB wins this tie.
    a2 = 64'h0000_0000_3333_0100;
    b2 = 64'h0000_0000_4444_0208;
    grant_q.delete();
    issue(1'b1, a2, 1'b1, b2);
    wait_done("round2");
    chk("round2_grants", 64'(grant_q.size()), 2);
    if (grant_q.size() >= 2) begin
      chk("round2_first", grant_q[0], b2);
      chk("round2_second", grant_q[1], a2);
    end

    // READY held low for five cycles.
    grant_q.delete(); acc_q.delete();
    t0 = cyc;
    issue(1'b1, 64'h0000_0000_8005_0200, 1'b0, '0);
    wait_done("stall");
    chk("stall_accepts", 64'(acc_q.size()), 1);
    if (acc_q.size() >= 1) chk("stall_accept_cycle", 64'(acc_q[0]), 64'(t0 + 2 + 5));

    // Timeout on DTLB, late response swallowed, queued ITLB request waits for the drain.
    at = 64'h0000_0000_5000_0C00;
    it = 64'h0000_0000_4000_0200;
    grant_q.delete(); acc_q.delete();
    issue(1'b0, '0, 1'b1, at);
    tick();
    issue(1'b1, it, 1'b0, '0);
    wait_done("timeout");
    chk("to_grants", 64'(grant_q.size()), 2);
    if (grant_q.size() >= 2) begin
      chk("to_first", grant_q[0], at);
      chk("to_second", grant_q[1], it);
      chk("to_after_drain", 64'(acc_q[1]), 64'(acc_q[0] + 12 + 2));
    end

    // Bus error on ITLB alongside a clean DTLB walk.
    issue(1'b1, 64'h0000_0000_1234_0508, 1'b1, 64'h0000_0000_6700_0400);
    wait_done("buserr");

    // Randomised traffic; requesters pulse only while their slot is free.
    for (int c = 0; c < 600; c++) begin
      bit di, dd;
      di = !i_out && ($urandom_range(0, 3) == 0);
      dd = !d_out && ($urandom_range(0, 3) == 0);
      if (di || dd) issue(di, rand_addr(), dd, rand_addr());
      else tick();
    end
    wait_done("random");
    chk("proto_clean", 64'(proto_err), 0);

    // Second ITLB pulse while the first is still outstanding.
    grant_q.delete();
    issue(1'b1, 64'h0000_0000_7000_0600, 1'b0, '0);
    i_req_valid = 1'b1;
    i_req_addr  = 64'h0000_0000_7100_0100;
    tick();
    i_req_valid = 1'b0;
    chk("proto_set", 64'(proto_err), 1);
    wait_done("proto");
    chk("proto_dropped", 64'(grant_q.size()), 1);
    chk("proto_sticky", 64'(proto_err), 1);

    // Asynchronous reset while waiting for a response.
    acc_q.delete();
    issue(1'b0, '0, 1'b1, 64'h0000_0000_0000_0700);
    n = 0;
    while (acc_q.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    chk("rst_accept_seen", 64'(acc_q.size() > 0), 1);
    tick();
    tick();
    chk("rst_busy_before", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset("rst_wait");
    d_exp.delete();
    i_exp.delete();
    d_out = 1'b0;
    i_out = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_idle_after", 64'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
